// File: rtl/bth_mlt_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per product.
// Operands are extended to WIDTH+1 bits, so signed and unsigned share a single datapath.
module bth_mlt_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     inp_q,
    input  logic [WIDTH-1:0]     inp_m,
    input  logic                 mode_signed,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;
    logic [AW-1:0]        m_q, m_d;
    logic [AW-1:0]        q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;

    logic [AW-1:0]        ext_q, ext_m;
    logic [AW-1:0]        sum;
    logic [AW-1:0]        a_sh, q_sh;
    logic                 q1_sh;

    // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,Q_1}.
    always_comb begin
        ext_q = {mode_signed & inp_q[WIDTH-1], inp_q};
        ext_m = {mode_signed & inp_m[WIDTH-1], inp_m};
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        a_sh  = {sum[AW-1], sum[AW-1:1]};
        q_sh  = {sum[0], q_q[AW-1:1]};
        q1_sh = q_q[0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    a_d     = '0;
                    q_d     = ext_q;
                    m_d     = ext_m;
                    q1_d    = 1'b0;
                    count_d = CW'(WIDTH + 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_sh;
                q_d     = q_sh;
                q1_d    = q1_sh;
                count_d = count_q - CW'(1);
                // The two top bits of the shifted {A,Q} are redundant sign bits.
                if (count_q == CW'(1)) begin
                    prod_d  = {a_sh[WIDTH-2:0], q_sh};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign prod = prod_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_bth_mlt_seq.sv
// Bench for bth_mlt_seq: directed WIDTH=4 vectors and corner sequences, plus random
// regressions at WIDTH 2/4/8/16 checked against an integer-arithmetic product model.
module tb_bth_mlt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int finished_count = 0;

    logic       m_rst, m_load, m_sg;
    logic [3:0] m_q, m_m;
    logic [7:0] m_prod;
    logic       m_busy, m_done;

    logic       rst_r;

    bth_mlt_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(m_rst), .load(m_load), .inp_q(m_q), .inp_m(m_m),
        .mode_signed(m_sg), .prod(m_prod), .busy(m_busy), .done(m_done)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] m;
        logic       sg;
        logic [7:0] exp;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts one operation from the current negedge and returns at the negedge showing done.
    // A pulse_at >= 1 raises load with new operands at that cycle of the run.
    task automatic applyStimulus(input logic [3:0] q, input logic [3:0] m, input logic sg,
                                 input int pulse_at, output logic [7:0] p, output int cycles,
                                 output int busy_cycles, output int overlap);
        logic [31:0] rv;
        m_q = q; m_m = m; m_sg = sg; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        cycles = 0; busy_cycles = 0; overlap = 0;
        while (1) begin
            if (m_busy) busy_cycles++;
            if (m_busy && m_done) overlap++;
            if (m_done || cycles > 20) break;
            @(negedge clk);
            cycles++;
            if (cycles == pulse_at) begin
                m_load = 1'b1; m_q = 4'h7; m_m = 4'h7; m_sg = 1'b1;
            end else begin
                rv = $urandom;
                m_load = 1'b0; m_q = rv[3:0]; m_m = rv[7:4]; m_sg = rv[8];
            end
        end
        p = m_prod;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    initial begin
        rst_r = 1'b0;
        #17 rst_r = 1'b1;
    end

    initial begin
        vec_t       vecs[10];
        logic [7:0] p;
        int         cycles, busy_cycles, overlap, dones;

        m_rst = 1'b0; m_load = 1'b0; m_sg = 1'b0; m_q = '0; m_m = '0;
        #12;
        checkOutput("reset_prod", m_prod, 8'h00);
        checkOutput("reset_busy", m_busy, 1'b0);
        checkOutput("reset_done", m_done, 1'b0);
        @(negedge clk);
        m_rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{4'h3, 4'h5, 1'b1, 8'h0F};
        vecs[1] = '{4'h4, 4'hD, 1'b1, 8'hF4};
        vecs[2] = '{4'hC, 4'h3, 1'b1, 8'hF4};
        vecs[3] = '{4'hC, 4'h3, 1'b0, 8'h24};
        vecs[4] = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vecs[5] = '{4'h8, 4'h8, 1'b1, 8'h40};
        vecs[6] = '{4'h8, 4'h7, 1'b1, 8'hC8};
        vecs[7] = '{4'h5, 4'h0, 1'b1, 8'h00};
        vecs[8] = '{4'hF, 4'h0, 1'b0, 8'h00};
        vecs[9] = '{4'h0, 4'h9, 1'b1, 8'h00};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].q, vecs[i].m, vecs[i].sg, -1, p, cycles, busy_cycles, overlap);
            checkOutput($sformatf("vec%0d_prod", i), p, vecs[i].exp);
            checkOutput($sformatf("vec%0d_latency", i), cycles, 5);
            checkOutput($sformatf("vec%0d_busy_cycles", i), busy_cycles, 5);
            checkOutput($sformatf("vec%0d_busy_done_overlap", i), overlap, 0);
            if (i == 0) begin
                @(negedge clk);
                checkOutput("done_pulse_width", m_done, 1'b0);
                checkOutput("prod_held", m_prod, 8'h0F);
            end
        end

        // A load two cycles into the run is ignored; a load right after done is accepted.
        applyStimulus(4'h3, 4'h5, 1'b1, 2, p, cycles, busy_cycles, overlap);
        checkOutput("ignored_load_prod", p, 8'h0F);
        checkOutput("ignored_load_latency", cycles, 5);
        applyStimulus(4'h7, 4'h7, 1'b1, -1, p, cycles, busy_cycles, overlap);
        checkOutput("back_to_back_prod", p, 8'h31);
        checkOutput("back_to_back_latency", cycles, 5);

        // Reset in the third RUN cycle aborts without a done pulse.
        m_q = 4'h7; m_m = 4'h7; m_sg = 1'b1; m_load = 1'b1;
        @(negedge clk);
        m_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 m_rst = 1'b0;
        #2 m_rst = 1'b1;
        checkOutput("abort_prod", m_prod, 8'h00);
        checkOutput("abort_busy", m_busy, 1'b0);
        checkOutput("abort_done", m_done, 1'b0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        checkOutput("abort_idle_busy", m_busy, 1'b0);
        applyStimulus(4'h2, 4'h3, 1'b1, -1, p, cycles, busy_cycles, overlap);
        checkOutput("after_abort_prod", p, 8'h06);
        checkOutput("after_abort_latency", cycles, 5);

        wait (finished_count == 4);
        summary();
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int W = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
        localparam logic [2*W-1:0] FIRST_EXP = {2'b01, {(2*W-2){1'b0}}};

        logic           r_load, r_sg;
        logic [W-1:0]   r_q, r_m;
        logic [2*W-1:0] r_prod;
        logic           r_busy, r_done;

        bth_mlt_seq #(.WIDTH(W)) dut_r (
            .clk(clk), .rst(rst_r), .load(r_load), .inp_q(r_q), .inp_m(r_m),
            .mode_signed(r_sg), .prod(r_prod), .busy(r_busy), .done(r_done)
        );

        function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sg);
            longint av, bv, pv;
            av = 0; bv = 0;
            av[W-1:0] = a;
            bv[W-1:0] = b;
            if (sg && a[W-1]) av = av - (longint'(1) << W);
            if (sg && b[W-1]) bv = bv - (longint'(1) << W);
            pv = av * bv;
            return pv[2*W-1:0];
        endfunction

        initial begin
            logic [2*W-1:0] exp_p;
            logic [31:0]    rv, rv2;
            int             cycles;
            r_load = 1'b0; r_sg = 1'b0; r_q = '0; r_m = '0;
            @(posedge rst_r);
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                if (i == 0) begin
                    r_q = {1'b1, {(W-1){1'b0}}};
                    r_m = {1'b1, {(W-1){1'b0}}};
                    r_sg = 1'b1;
                end else begin
                    rv = $urandom; rv2 = $urandom;
                    r_q = rv[W-1:0]; r_m = rv2[W-1:0]; r_sg = rv[31];
                end
                exp_p = model(r_q, r_m, r_sg);
                r_load = 1'b1;
                @(negedge clk);
                cycles = 0;
                while (!r_done && cycles <= W + 4) begin
                    rv = $urandom; rv2 = $urandom;
                    r_load = rv[31]; r_q = rv[W-1:0]; r_m = rv2[W-1:0]; r_sg = rv2[31];
                    @(negedge clk);
                    cycles++;
                end
                checkOutput($sformatf("w%0d_op%0d_prod", W, i), r_prod, exp_p);
                checkOutput($sformatf("w%0d_op%0d_latency", W, i), cycles, W + 1);
                if (i == 0)
                    checkOutput($sformatf("w%0d_min_squared", W), r_prod, FIRST_EXP);
            end
            r_load = 1'b0;
            finished_count++;
        end
    end

    initial begin
        #800000;
        mismatched++;
        $display("[TB] FAIL watchdog: actual=timeout required=all operations complete");
        summary();
        $finish;
    end

endmodule

// File: doc/bth_mlt_seq.md
# bth_mlt_seq

Parametrised sequential radix-2 Booth multiplier, the generalised successor to the fixed 4-bit `bth_mlt`. It multiplies two WIDTH-bit operands, signed or unsigned as selected per operation, and produces a 2*WIDTH-bit product. It iterates one Booth step per clock, adds busy/done status, and ignores new loads while an operation is in progress. It sits in the arithmetic datapath wherever a low-area multi-cycle multiply is acceptable.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- load  input  1  start request; sampled only in IDLE.
- inp_q  input  WIDTH  multiplier (Q).
- inp_m  input  WIDTH  multiplicand (M).
- mode_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with load.
- prod  output  2*WIDTH  product of the last completed operation; held until the next completion.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when prod updates.

## Operation
- Internal registers:
  - A: WIDTH+1 bits.
  - M: WIDTH+1 bits.
  - Q: WIDTH+1 bits.
  - Q_1: 1 bit.
  - count: sized for WIDTH+1.
  - state: IDLE or RUN.
- Operand extension: inp_q and inp_m are extended to WIDTH+1 bits. Signed mode uses sign extension; unsigned mode uses zero extension. The mode is latched at load and used for the whole operation.
- IDLE, load=1 at the edge:
  - A=0, Q=ext(inp_q), M=ext(inp_m), Q_1=0, count=WIDTH+1.
  - state goes to RUN; busy=1.
- RUN, each edge performs one iteration:
  - {Q[0],Q_1}=01: A=A+M.
  - {Q[0],Q_1}=10: A=A-M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {A,Q,Q_1} by one, with A's MSB replicated.
  - count decrements by 1.
- Arithmetic is modulo 2^(WIDTH+1) on A; the intermediate sum is never saturated.
- Final iteration (count==1):
  - The shifted result is computed combinationally.
  - prod <= low 2*WIDTH bits of the shifted {A,Q}.
  - done=1; busy=0; state goes to IDLE.
- Because the product fits in 2*WIDTH bits for every operand pair in either mode, truncating the low bits is exact.
- load while in RUN (busy=1) is ignored. The operation in flight is unaffected; inp_q, inp_m and mode_signed may change freely during RUN.
- load is not accepted on the completion edge itself. It is accepted at the first edge after done.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, prod=0, busy=0, done=0, and all internal registers are 0. Reset mid-operation aborts it, no done pulse is produced, and prod reads 0.
- Latency: load is accepted at edge E0. busy is high from E0 until E_(WIDTH+1). prod and done update at E_(WIDTH+1), so WIDTH+1 cycles elapse from load to result.
- done is high for exactly the one cycle following E_(WIDTH+1).
- Back-to-back throughput: one result every WIDTH+2 cycles. load is held high continuously only if the bench restarts immediately after done.
- prod is stable between completions; it changes only at a completion edge or at reset.
- busy and done are never high in the same cycle.

## Test plan
- WIDTH=4, signed, inp_q=3, inp_m=5, load for 1 cycle -> after 5 cycles done pulses for 1 cycle; prod=8'h0F; busy was high for exactly 5 cycles.
- WIDTH=4, signed, inp_q=4, inp_m=-3 (4'hD) -> prod=8'hF4 (-12). Same bits with q=4'hC, m=4'h3: signed gives 8'hF4, unsigned gives 8'h24 (36).
- WIDTH=4 extremes:
  - unsigned 15*15 -> 8'hE1.
  - signed -8*-8 -> 8'h40.
  - signed -8*7 -> 8'hC8.
  - anything*0 -> 8'h00.
- Load ignored while busy: start 3*5 signed, pulse load with 7*7 two cycles later and change the inputs -> the only done shows prod=8'h0F. A load on the first cycle after done then yields 8'h31.
- Reset mid-operation: start 7*7, drop rst for 2 ns during the third RUN cycle -> prod=0, busy=0, no done. A following 2*3 produces 8'h06 with normal latency.
- WIDTH=8 signed -128*-128 -> 16'h4000 after 9 cycles. Plus a random regression of 1000 operand/mode triples per WIDTH in {2,4,8,16}, checked against a behavioural model.
